// File: rtl/cpu_pkg.sv
// Shared encodings for the stack CPU control path: instruction classes,
// SYS sub-codes, sequencer states and stack-pointer control bit positions.
package cpu_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int INSTR_W_DEF = 18;

    localparam logic [1:0] CLS_ALU  = 2'b00;
    localparam logic [1:0] CLS_PUSH = 2'b01;
    localparam logic [1:0] CLS_JMP  = 2'b10;
    localparam logic [1:0] CLS_SYS  = 2'b11;

    localparam logic [1:0] SYS_NOP  = 2'b00;
    localparam logic [1:0] SYS_POP  = 2'b01;
    localparam logic [1:0] SYS_HALT = 2'b10;
    localparam logic [1:0] SYS_JC   = 2'b11;

    typedef logic [2:0] state_t;
    localparam state_t S_FETCH = 3'd0;
    localparam state_t S_EX1   = 3'd1;
    localparam state_t S_EX2   = 3'd2;
    localparam state_t S_WB    = 3'd3;
    localparam state_t S_HALT  = 3'd4;

    localparam int SP_SEL = 2;
    localparam int SP_INC = 1;
    localparam int SP_DEC = 0;

    function automatic logic [15:0] sext14(input logic [13:0] v);
        return {{2{v[13]}}, v};
    endfunction

endpackage

// File: rtl/control_sequencer_instr_decode.sv
// Combinational field extraction for the 18-bit stack CPU instruction word.
module instr_decode
    import cpu_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic [INSTR_W-1:0] i_ir,
    output logic [1:0]         o_cls,
    output logic [1:0]         o_sub,
    output logic [15:0]        o_imm,
    output logic [15:0]        o_offset,
    output logic [5:0]         o_alu_op
);

    assign o_cls    = i_ir[17:16];
    assign o_sub    = i_ir[15:14];
    assign o_imm    = i_ir[15:0];
    assign o_offset = sext14(i_ir[13:0]);
    assign o_alu_op = i_ir[5:0];

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute/writeback sequencer driving the stack, stack pointer and ALU.
// Optional build macro SINGLE_STEP_EN adds i_step to gate each instruction fetch.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int          DATA_W      = DATA_W_DEF,
    parameter int          INSTR_W     = INSTR_W_DEF,
    parameter int          STACK_DEPTH = 256,
    parameter logic [15:0] RESET_PC    = 16'h0000
) (
    input  logic               i_clk,
    input  logic               i_rst,
`ifdef SINGLE_STEP_EN
    input  logic               i_step,
`endif
    output logic [15:0]        o_pc,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [DATA_W-1:0]  i_stk_top,
    input  logic [15:0]        i_sp_count,
    output logic [DATA_W-1:0]  o_bus_data,
    output logic               o_bus_oe,
    output logic               o_stk_w,
    output logic               o_stk_s,
    output logic [2:0]         o_sp_ctrl,
    output logic [DATA_W-1:0]  o_alu_a,
    output logic [5:0]         o_alu_op,
    input  logic [DATA_W-1:0]  i_alu_out,
    input  logic               i_alu_carry,
    output logic               o_carry,
    output logic               o_halted,
    output logic               o_fault
);

    localparam logic [16:0] DEPTH_LIM = 17'(STACK_DEPTH);

    state_t               state_q, state_d;
    logic [15:0]          pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]    a_q, a_d;
    logic [DATA_W-1:0]    res_q, res_d;
    logic                 carry_q, carry_d;
    logic                 fault_q, fault_d;
    logic                 step_ok;

    logic [1:0]  dec_cls;
    logic [1:0]  dec_sub;
    logic [15:0] dec_imm;
    logic [15:0] dec_offset;
    logic [5:0]  dec_alu_op;

`ifdef SINGLE_STEP_EN
    assign step_ok = i_step;
`else
    assign step_ok = 1'b1;
`endif

    instr_decode #(.INSTR_W(INSTR_W)) u_decode (
        .i_ir     (ir_q),
        .o_cls    (dec_cls),
        .o_sub    (dec_sub),
        .o_imm    (dec_imm),
        .o_offset (dec_offset),
        .o_alu_op (dec_alu_op)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        res_d      = res_q;
        carry_d    = carry_q;
        fault_d    = fault_q;
        o_bus_data = '0;
        o_bus_oe   = 1'b0;
        o_stk_w    = 1'b0;
        o_stk_s    = 1'b0;
        o_sp_ctrl  = 3'b000;
        o_alu_a    = '0;
        o_alu_op   = 6'd0;

        // Outputs are suppressed while reset is asserted so an aborted
        // instruction cannot emit a strobe in the reset cycle itself.
        if (!i_rst) begin
            case (state_q)
                S_FETCH: begin
                    if (step_ok) begin
                        ir_d    = i_instr;
                        state_d = S_EX1;
                    end
                end
                S_EX1: begin
                    case (dec_cls)
                        CLS_ALU: begin
                            if (i_sp_count < 16'd2) begin
                                fault_d = 1'b1;
                                state_d = S_HALT;
                            end else begin
                                a_d               = i_stk_top;
                                o_sp_ctrl[SP_SEL] = 1'b1;
                                o_sp_ctrl[SP_DEC] = 1'b1;
                                state_d           = S_EX2;
                            end
                        end
                        CLS_PUSH: begin
                            if ({1'b0, i_sp_count} >= DEPTH_LIM) begin
                                fault_d = 1'b1;
                                state_d = S_HALT;
                            end else begin
                                o_sp_ctrl[SP_SEL] = 1'b1;
                                o_sp_ctrl[SP_INC] = 1'b1;
                                state_d           = S_WB;
                            end
                        end
                        CLS_JMP: begin
                            pc_d    = dec_imm;
                            state_d = S_FETCH;
                        end
                        default: begin
                            case (dec_sub)
                                SYS_NOP: begin
                                    pc_d    = pc_q + 16'd1;
                                    state_d = S_FETCH;
                                end
                                SYS_POP: begin
                                    if (i_sp_count == 16'd0) begin
                                        fault_d = 1'b1;
                                        state_d = S_HALT;
                                    end else begin
                                        o_sp_ctrl[SP_SEL] = 1'b1;
                                        o_sp_ctrl[SP_DEC] = 1'b1;
                                        pc_d              = pc_q + 16'd1;
                                        state_d           = S_FETCH;
                                    end
                                end
                                SYS_HALT: state_d = S_HALT;
                                default: begin
                                    pc_d    = carry_q ? (pc_q + dec_offset) : (pc_q + 16'd1);
                                    state_d = S_FETCH;
                                end
                            endcase
                        end
                    endcase
                end
                S_EX2: begin
                    o_alu_a  = a_q;
                    o_alu_op = dec_alu_op;
                    res_d    = i_alu_out;
                    carry_d  = i_alu_carry;
                    state_d  = S_WB;
                end
                S_WB: begin
                    // ALU already dropped one entry in EX1; result overwrites the new top.
                    o_bus_oe   = 1'b1;
                    o_stk_s    = 1'b1;
                    o_stk_w    = 1'b1;
                    o_bus_data = (dec_cls == CLS_PUSH) ? DATA_W'(dec_imm) : res_q;
                    pc_d       = pc_q + 16'd1;
                    state_d    = S_FETCH;
                end
                S_HALT: state_d = S_HALT;
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            fault_q <= fault_d;
        end
    end

    assign o_pc     = pc_q;
    assign o_carry  = carry_q;
    assign o_fault  = fault_q;
    assign o_halted = (state_q == S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed and randomized bench for control_sequencer, with a ROM, an emulated
// stack driven by the sequencer strobes, and an instruction-level reference model.
module tb_control_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
`ifdef SINGLE_STEP_EN
    logic        i_step = 1'b1;
`endif
    logic [15:0] o_pc;
    logic [17:0] i_instr;
    logic [15:0] i_stk_top;
    logic [15:0] i_sp_count;
    logic [15:0] o_bus_data;
    logic        o_bus_oe;
    logic        o_stk_w;
    logic        o_stk_s;
    logic [2:0]  o_sp_ctrl;
    logic [15:0] o_alu_a;
    logic [5:0]  o_alu_op;
    logic [15:0] i_alu_out;
    logic        i_alu_carry;
    logic        o_carry;
    logic        o_halted;
    logic        o_fault;

    logic [17:0] rom [0:65535];
    logic [15:0] emu_mem [0:511];
    int          emu_sp = 0;
    logic        cnt_ovr_en = 1'b0;
    logic [15:0] cnt_ovr = 16'h0;
    logic [16:0] alu_sum;

    int          n_checks = 0;
    int          n_errors = 0;

    logic [15:0] m_stk[$];
    logic [15:0] m_pc;
    logic        m_carry;
    logic        m_halt;
    logic        m_fault;
    int          m_cycles;

    control_sequencer dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
`ifdef SINGLE_STEP_EN
        .i_step      (i_step),
`endif
        .o_pc        (o_pc),
        .i_instr     (i_instr),
        .i_stk_top   (i_stk_top),
        .i_sp_count  (i_sp_count),
        .o_bus_data  (o_bus_data),
        .o_bus_oe    (o_bus_oe),
        .o_stk_w     (o_stk_w),
        .o_stk_s     (o_stk_s),
        .o_sp_ctrl   (o_sp_ctrl),
        .o_alu_a     (o_alu_a),
        .o_alu_op    (o_alu_op),
        .i_alu_out   (i_alu_out),
        .i_alu_carry (i_alu_carry),
        .o_carry     (o_carry),
        .o_halted    (o_halted),
        .o_fault     (o_fault)
    );

    always #5 i_clk = ~i_clk;

    // ROM, stack memory and ALU stub seen by the sequencer
    assign i_instr     = rom[o_pc];
    assign i_sp_count  = cnt_ovr_en ? cnt_ovr : 16'(emu_sp);
    assign i_stk_top   = (emu_sp > 0) ? emu_mem[9'(emu_sp - 1)] : 16'h0;
    assign alu_sum     = {1'b0, o_alu_a} + {1'b0, i_stk_top};
    assign i_alu_out   = alu_sum[15:0];
    assign i_alu_carry = alu_sum[16] | o_alu_op[5];

    always @(posedge i_clk) begin
        if (i_rst) begin
            emu_sp <= 0;
        end else begin
            if (o_sp_ctrl[1] && emu_sp < 512) emu_sp <= emu_sp + 1;
            else if (o_sp_ctrl[0] && emu_sp > 0) emu_sp <= emu_sp - 1;
            if (o_stk_w && emu_sp > 0) emu_mem[9'(emu_sp - 1)] <= o_bus_data;
        end
    end

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        i_rst = 1'b1;
        tick;
        tick;
        i_rst = 1'b0;
        m_pc    = 16'h0000;
        m_carry = 1'b0;
        m_halt  = 1'b0;
        m_fault = 1'b0;
        m_stk.delete();
    endtask

    function automatic logic [17:0] enc_push(input logic [15:0] v); return {2'b01, v}; endfunction
    function automatic logic [17:0] enc_alu(input logic [5:0] op); return {2'b00, 10'h0, op}; endfunction
    function automatic logic [17:0] enc_jmp(input logic [15:0] t); return {2'b10, t}; endfunction
    function automatic logic [17:0] enc_sys(input logic [1:0] s, input logic [13:0] o); return {2'b11, s, o}; endfunction

    // Executes rom[m_pc] on the abstract machine: stack as a queue, PC as an integer mod 65536.
    task automatic model_step;
        logic [17:0] ins;
        logic [15:0] a;
        logic [15:0] b;
        int          sum;
        int          off;
        ins      = rom[m_pc];
        m_cycles = 2;
        case (ins[17:16])
            2'b00: begin
                if (m_stk.size() < 2) begin
                    m_fault = 1'b1;
                end else begin
                    a        = m_stk.pop_back();
                    b        = m_stk[$];
                    sum      = int'(a) + int'(b);
                    m_stk[$] = 16'(sum % 65536);
                    m_carry  = (sum >= 65536) || (ins[5] == 1'b1);
                    m_pc     = 16'((int'(m_pc) + 1) % 65536);
                    m_cycles = 4;
                end
            end
            2'b01: begin
                if (m_stk.size() >= 256) begin
                    m_fault = 1'b1;
                end else begin
                    m_stk.push_back(ins[15:0]);
                    m_pc     = 16'((int'(m_pc) + 1) % 65536);
                    m_cycles = 3;
                end
            end
            2'b10: m_pc = ins[15:0];
            default: begin
                if (ins[15:14] == 2'd0) begin
                    m_pc = 16'((int'(m_pc) + 1) % 65536);
                end else if (ins[15:14] == 2'd1) begin
                    if (m_stk.size() == 0) m_fault = 1'b1;
                    else begin
                        void'(m_stk.pop_back());
                        m_pc = 16'((int'(m_pc) + 1) % 65536);
                    end
                end else if (ins[15:14] == 2'd2) begin
                    m_halt = 1'b1;
                end else begin
                    off = int'(ins[13:0]);
                    if (off >= 8192) off = off - 16384;
                    if (m_carry) m_pc = 16'((int'(m_pc) + off + 65536) % 65536);
                    else m_pc = 16'((int'(m_pc) + 1) % 65536);
                end
            end
        endcase
        if (m_fault) m_halt = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) rom[i] = 18'h0;

        // Reset state and a single PUSH
        rom[0] = enc_push(16'h1234);
        do_reset;
        check("rst_pc", o_pc, 16'h0000);
        check("rst_flags", {o_halted, o_fault, o_carry}, 3'b000);
        check("rst_idle", {o_bus_oe, o_stk_w, o_stk_s, o_sp_ctrl, o_alu_op}, 12'h0);
        tick;
        check("push_ex1_sp", o_sp_ctrl, 3'b110);
        tick;
        check("push_wb_strobes", {o_bus_oe, o_stk_s, o_stk_w, o_sp_ctrl}, 6'b111000);
        check("push_wb_bus", o_bus_data, 16'h1234);
        tick;
        check("push_pc", o_pc, 16'h0001);
        check("push_stack", {i_sp_count, i_stk_top}, {16'd1, 16'h1234});

        // ALU op, conditional branch both ways, PC wrap
        rom[0] = enc_push(16'd5);
        rom[1] = enc_push(16'd3);
        rom[2] = enc_alu(6'h20);
        rom[3] = enc_jmp(16'h0010);
        rom[16'h0010] = enc_sys(2'b11, 14'h3FFE);
        rom[16'h000E] = enc_push(16'd1);
        rom[16'h000F] = enc_alu(6'h00);
        rom[16'h0011] = enc_jmp(16'hFFFF);
        rom[16'hFFFF] = enc_sys(2'b00, 14'h0);
        do_reset;
        repeat (6) tick;
        check("alu_pre_stack", {i_sp_count, i_stk_top}, {16'd2, 16'd3});
        tick;
        check("alu_ex1_sp", o_sp_ctrl, 3'b101);
        tick;
        check("alu_ex2_a", o_alu_a, 16'd3);
        check("alu_ex2_op", o_alu_op, 6'h20);
        tick;
        check("alu_wb", {o_bus_oe, o_stk_w, o_bus_data, o_alu_op}, {1'b1, 1'b1, 16'd8, 6'h0});
        check("alu_carry", o_carry, 1'b1);
        tick;
        check("alu_pc", o_pc, 16'h0003);
        check("alu_stack", {i_sp_count, i_stk_top}, {16'd1, 16'd8});
        repeat (2) tick;
        check("jmp_pc", o_pc, 16'h0010);
        repeat (2) tick;
        check("jc_taken_pc", o_pc, 16'h000E);
        repeat (3 + 4) tick;
        check("alu2_result", {o_pc, i_stk_top, o_carry}, {16'h0010, 16'd9, 1'b0});
        repeat (2) tick;
        check("jc_not_taken_pc", o_pc, 16'h0011);
        repeat (2) tick;
        check("jmp_ffff_pc", o_pc, 16'hFFFF);
        repeat (2) tick;
        check("nop_wrap_pc", o_pc, 16'h0000);

        // Stack underflow / overflow faults
        rom[0] = enc_sys(2'b01, 14'h0);
        do_reset;
        tick;
        check("pop_uf_no_sp", {o_sp_ctrl, o_stk_w}, 4'b0000);
        tick;
        check("pop_uf_fault", {o_fault, o_halted, o_pc}, {1'b1, 1'b1, 16'h0000});
        rom[0] = enc_alu(6'h01);
        do_reset;
        cnt_ovr_en = 1'b1;
        cnt_ovr    = 16'd1;
        tick;
        check("alu_uf_no_sp", o_sp_ctrl, 3'b000);
        tick;
        check("alu_uf_fault", {o_fault, o_halted}, 2'b11);
        rom[0] = enc_push(16'hBEEF);
        do_reset;
        cnt_ovr = 16'd256;
        tick;
        check("push_of_no_sp", o_sp_ctrl, 3'b000);
        tick;
        check("push_of_fault", {o_fault, o_halted, o_stk_w, o_bus_oe}, 4'b1100);
        do_reset;
        cnt_ovr = 16'd255;
        tick;
        check("push_255_sp", o_sp_ctrl, 3'b110);
        repeat (2) tick;
        check("push_255_ok", {o_fault, o_halted, o_pc}, {1'b0, 1'b0, 16'h0001});
        cnt_ovr_en = 1'b0;

        // HALT stays idle
        rom[0] = enc_sys(2'b10, 14'h0);
        do_reset;
        repeat (2) tick;
        check("halt_flags", {o_halted, o_fault}, 2'b10);
        for (int i = 0; i < 20; i++) begin
            check("halt_idle", {o_bus_oe, o_stk_w, o_stk_s, o_sp_ctrl, o_alu_op, o_pc, o_halted},
                  {1'b0, 1'b0, 1'b0, 3'b000, 6'h0, 16'h0000, 1'b1});
            tick;
        end

        // Reset during EX2 of an ALU op
        rom[0] = enc_push(16'd7);
        rom[1] = enc_push(16'd9);
        rom[2] = enc_alu(6'h01);
        do_reset;
        repeat (8) tick;
        check("abort_in_ex2", o_alu_op, 6'h01);
        i_rst = 1'b1;
        check("abort_rst_cycle", {o_stk_w, o_bus_oe, o_sp_ctrl}, 5'b0);
        tick;
        i_rst = 1'b0;
        check("abort_after_rst", {o_pc, o_stk_w, o_bus_oe, o_halted, o_carry}, {16'h0000, 4'b0000});
        tick;
        check("abort_no_wb", {o_stk_w, o_bus_oe}, 2'b00);

`ifdef SINGLE_STEP_EN
        rom[0] = enc_push(16'h00AA);
        rom[1] = enc_push(16'h00BB);
        i_step = 1'b0;
        do_reset;
        repeat (10) tick;
        check("step_hold", {o_pc, i_sp_count, o_sp_ctrl}, {16'h0000, 16'd0, 3'b000});
        i_step = 1'b1;
        tick;
        i_step = 1'b0;
        check("step_ex1", o_sp_ctrl, 3'b110);
        repeat (2) tick;
        check("step_one_push", {o_pc, i_sp_count, i_stk_top}, {16'h0001, 16'd1, 16'h00AA});
        repeat (5) tick;
        check("step_frozen", {o_pc, i_sp_count}, {16'h0001, 16'd1});
        i_step = 1'b1;
`endif

        // Randomized programs against the reference model
        for (int i = 0; i < 65536; i++) begin
            int r;
            int s;
            r = $urandom_range(0, 99);
            if (r < 25) rom[i] = enc_alu(6'($urandom));
            else if (r < 60) rom[i] = enc_push(16'($urandom));
            else if (r < 64) rom[i] = enc_jmp(16'($urandom));
            else begin
                s = $urandom_range(0, 9);
                if (s < 3) rom[i] = enc_sys(2'b00, 14'($urandom));
                else if (s < 6) rom[i] = enc_sys(2'b01, 14'($urandom));
                else if (s < 7) rom[i] = enc_sys(2'b10, 14'($urandom));
                else rom[i] = enc_sys(2'b11, 14'($urandom));
            end
        end
        do_reset;
        for (int n = 0; n < 400; n++) begin
            model_step;
            repeat (m_cycles) tick;
            check("rnd_pc", o_pc, m_pc);
            check("rnd_depth", i_sp_count, 16'(m_stk.size()));
            if (m_stk.size() > 0) check("rnd_top", i_stk_top, m_stk[$]);
            check("rnd_flags", {o_carry, o_halted, o_fault}, {m_carry, m_halt, m_fault});
            if (m_halt) begin
                repeat (3) tick;
                check("rnd_halt_hold", {o_pc, o_halted, o_stk_w, o_sp_ctrl}, {m_pc, 1'b1, 1'b0, 3'b000});
                do_reset;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Instruction sequencer and control-signal initiator for the 16-bit stack CPU.
- Drives the program ROM address and registers the returned instruction.
- Decodes it and sequences the control inputs of the memory stack, stack pointer and ALU across multi-cycle fetch/execute/writeback states.
- Sits in the cpu top between the ROM and the datapath blocks; replaces hand-tied control wires.

Parameters:
DATA_W, 16, datapath/bus width
INSTR_W, 18, instruction width
STACK_DEPTH, 256, max stack entries (overflow limit)
RESET_PC, 0, PC value after reset

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  synchronous active-high reset
o_pc  out  16  program ROM address
i_instr  in  INSTR_W  ROM data (combinational from o_pc)
i_stk_top  in  DATA_W  stack top word
i_sp_count  in  16  current stack entry count (0 = empty)
o_bus_data  out  DATA_W  value driven onto shared bus
o_bus_oe  out  1  bus drive enable (top-level tri-state)
o_stk_w  out  1  stack write strobe (writes bus at top)
o_stk_s  out  1  stack select
o_sp_ctrl  out  3  {select, inc, dec} to stack pointer
o_alu_a  out  DATA_W  ALU operand A (B = stack top)
o_alu_op  out  6  ALU operation code
i_alu_out  in  DATA_W  ALU result
i_alu_carry  in  1  ALU carry out
o_carry  out  1  registered carry flag
o_halted  out  1  sequencer stopped (HALT or fault)
o_fault  out  1  stack over/underflow occurred

Behaviour:
- Reset: synchronous, active-high. Effects: PC=RESET_PC, state=FETCH, IR=0, A=0, carry=0, o_halted=0, o_fault=0. All strobes/oe/sp_ctrl=0. Reset mid-instruction aborts it with no further strobes.
- Instruction encoding, class = [17:16]:
  - 00 ALU: op=[5:0]
  - 01 PUSH: imm=[15:0]
  - 10 JMP: target=[15:0]
  - 11 SYS: sub=[15:14]
    - 00 NOP
    - 01 POP
    - 10 HALT
    - 11 JC: offset=sext([13:0]); if carry, PC=PC+offset, else PC+1
- States: FETCH, EX1, EX2, WB, HALT.
- FETCH: IR<=i_instr. Go to EX1.
- EX1:
  - ALU: requires count>=2, else FAULT. A<=i_stk_top; sp dec; ->EX2.
  - PUSH: requires count<STACK_DEPTH, else FAULT. sp inc; ->WB.
  - POP: requires count>=1, else FAULT. sp dec; PC+1; ->FETCH.
  - JMP: PC<=target; ->FETCH.
  - JC: branch per rule above; ->FETCH.
  - NOP: PC+1; ->FETCH.
  - HALT: ->HALT; PC unchanged.
- EX2 (ALU only): o_alu_a=A, o_alu_op=IR[5:0]; result reg<=i_alu_out; carry<=i_alu_carry; ->WB.
- WB: o_bus_oe=1, o_stk_s=1, o_stk_w=1. Bus carries imm (PUSH) or result (ALU). No SP change (ALU net depth -1). PC+1; ->FETCH.
- Cycle counts: ALU 4, PUSH 3, POP/JMP/JC/NOP 2.
- Outputs outside their state: o_alu_op=0 except EX2. o_bus_oe=0 except WB.
- Carry updates only on ALU ops.
- PC arithmetic is modulo 2^16; 0xFFFF+1=0x0000; JC wraps likewise.
- FAULT: o_fault=1, o_halted=1, state=HALT. Faulting instruction issues no strobes.
- HALT: all strobes 0, sticky until reset.
- o_sp_ctrl select bit=1 whenever inc or dec is 1.

Optional Feature:
SINGLE_STEP_EN
- Defined: adds input i_step (1 bit). FETCH holds (no IR load, outputs idle) until i_step=1 is sampled, then proceeds. Each i_step pulse runs exactly one instruction to completion. i_step held high runs continuously.
- Undefined: port absent; FETCH always proceeds.

Decomposition:
- Package cpu_pkg holds:
  - class codes, SYS sub-codes
  - state enum
  - sp_ctrl bit indices (SEL/INC/DEC)
  - DATA_W/INSTR_W defaults
- Sub-module instr_decode (combinational): IR -> class, sub-op, imm, sext offset, alu_op.

Test Plan:
1. Reset, PUSH 0x1234 -> EX1 sp_ctrl=110; WB bus_oe=1, stk_w=1, bus_data=0x1234; PC=1 after 3 cycles.
2. PUSH 5, PUSH 3, ALU op with stub out=8, carry=1 -> EX1 A=3 sp dec; WB writes 8; o_carry=1; PC=3.
3. Carry=1, JC offset -2 at PC=0x0010 -> PC=0x000E. Carry=0 -> PC=0x0011. JMP 0xFFFF then NOP -> PC=0x0000.
4. count=0, POP -> o_fault=1, o_halted=1, no sp_ctrl pulse. count=STACK_DEPTH, PUSH -> fault.
5. HALT -> o_halted=1, outputs idle 20 cycles; i_rst mid-EX2 of ALU op -> next cycle PC=RESET_PC, no WB strobe.
6. (SINGLE_STEP_EN) i_step=0 for 10 cycles -> PC frozen; one-cycle pulse -> exactly one PUSH completes.
